// File: rtl/face_x_tracker.sv
// ----------------------------------------------------------------------------
// face_x_tracker
//
// Tracks the horizontal face position for the picture selector. The x
// coordinates of every classified hit pixel are summed over a frame. At
// frame_end the sum and count are latched, and a restoring divider computes
// the centroid, one quotient bit per cycle, MSB first. One updated x is
// published per frame.
//
// Timing: frame_end sampled in cycle N -> CHECK in N+1 -> DIV in N+2..N+11 ->
// DONE in N+12. x and x_valid are both visible in N+12. The next frame_end
// is accepted from N+13.
//
// Optional build macro: FACE_X_SMOOTH_EN
//   When this macro is defined, the new x is (3*x + q) >> 2. The first valid
//   frame after reset, or after a no_target frame, loads q directly.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   frame_start in   one-cycle pulse on the first pixel of a frame
//   frame_end   in   one-cycle pulse on the last pixel of a frame
//   pix_valid   in   pixel qualifier
//   pix_hit     in   classifier decision (1 = face/skin)
//   pix_x       in   pixel column, 0..639
//   x           out  tracked face x-position
//   x_valid     out  one-cycle strobe when x updates
//   no_target   out  last completed frame had fewer than MIN_HITS hits
//   busy        out  divider running (CHECK/DIV/DONE)
//   overrun     out  one-cycle pulse when a frame_end is dropped
// ----------------------------------------------------------------------------
module face_x_tracker #(
    parameter int                XW       = 10,
    parameter int                CNT_W    = 19,
    parameter int                SUM_W    = 29,
    parameter logic [CNT_W-1:0]  MIN_HITS = 19'd256,
    parameter logic [XW-1:0]     X_INIT   = 10'd320
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          frame_end,
    input  logic          pix_valid,
    input  logic          pix_hit,
    input  logic [XW-1:0] pix_x,
    output logic [XW-1:0] x,
    output logic          x_valid,
    output logic          no_target,
    output logic          busy,
    output logic          overrun
);

    localparam int             IW       = $clog2(XW);
    localparam logic [IW-1:0]  LAST_BIT = IW'(XW - 1);
    localparam logic [XW-1:0]  X_MAX    = 10'd639;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DIV   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [SUM_W-1:0]    acc_sum_r, acc_sum_next_s, base_sum_s;
    logic [CNT_W-1:0]    acc_cnt_r, acc_cnt_next_s, base_cnt_s;
    logic [SUM_W:0]      sum_ext_s;
    logic [CNT_W:0]      cnt_ext_s;
    logic [SUM_W-1:0]    snap_sum_r;
    logic [CNT_W-1:0]    snap_cnt_r;
    logic [SUM_W:0]      rem_r, shifted_s, div_rem_s;
    logic [XW-1:0]       q_r, q_step_s, q_clamp_s, x_new_s;
    logic [IW-1:0]       bit_idx_r;
    logic                div_ge_s, div_last_s;
    logic                fe_accept_s, fe_drop_s;
    logic [XW-1:0]       x_r;
    logic                x_valid_r, no_target_r, busy_r, overrun_r;
`ifdef FACE_X_SMOOTH_EN
    logic                load_direct_r;
    logic [XW+1:0]       smooth_sum_s;
`endif

    assign fe_accept_s = frame_end && (state_r == ST_IDLE);
    assign fe_drop_s   = frame_end && (state_r != ST_IDLE);
    assign div_last_s  = (state_r == ST_DIV) && (bit_idx_r == {IW{1'b0}});

    // Next accumulator values. frame_start clears first, so a hit on that cycle belongs to the new frame.
    always_comb begin
        base_sum_s = frame_start ? {SUM_W{1'b0}} : acc_sum_r;
        base_cnt_s = frame_start ? {CNT_W{1'b0}} : acc_cnt_r;
        sum_ext_s  = {1'b0, base_sum_s} + {{(SUM_W + 1 - XW){1'b0}}, pix_x};
        cnt_ext_s  = {1'b0, base_cnt_s} + {{CNT_W{1'b0}}, 1'b1};
        if (pix_valid && pix_hit) begin
            // A carry out means the sum overflowed, so saturate instead of wrapping.
            acc_sum_next_s = sum_ext_s[SUM_W] ? {SUM_W{1'b1}} : sum_ext_s[SUM_W-1:0];
            acc_cnt_next_s = cnt_ext_s[CNT_W] ? {CNT_W{1'b1}} : cnt_ext_s[CNT_W-1:0];
        end else begin
            acc_sum_next_s = base_sum_s;
            acc_cnt_next_s = base_cnt_s;
        end
    end

    // Accumulator registers. They clear when a frame_end is accepted and handed to the divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum_r <= {SUM_W{1'b0}};
            acc_cnt_r <= {CNT_W{1'b0}};
        end else if (fe_accept_s) begin
            acc_sum_r <= {SUM_W{1'b0}};
            acc_cnt_r <= {CNT_W{1'b0}};
        end else begin
            acc_sum_r <= acc_sum_next_s;
            acc_cnt_r <= acc_cnt_next_s;
        end
    end

    // One restoring-division step. The compare is one bit wider than the sum, so the shifted divisor cannot overflow.
    always_comb begin
        shifted_s = {{(SUM_W + 1 - CNT_W){1'b0}}, snap_cnt_r} << bit_idx_r;
        div_ge_s  = (rem_r >= shifted_s);
        div_rem_s = div_ge_s ? (rem_r - shifted_s) : rem_r;
        q_step_s  = q_r;
        q_step_s[bit_idx_r] = div_ge_s;
        q_clamp_s = (q_step_s > X_MAX) ? X_MAX : q_step_s;
`ifdef FACE_X_SMOOTH_EN
        smooth_sum_s = ({2'b00, x_r} << 1) + {2'b00, x_r} + {2'b00, q_clamp_s};
        x_new_s      = load_direct_r ? q_clamp_s : smooth_sum_s[XW+1:2];
`else
        x_new_s      = q_clamp_s;
`endif
    end

    // Next-state logic for the divider FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = fe_accept_s ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_next_s = (snap_cnt_r < MIN_HITS) ? ST_IDLE : ST_DIV;
            ST_DIV:   state_next_s = (bit_idx_r == {IW{1'b0}}) ? ST_DONE : ST_DIV;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Snapshot and divider datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_sum_r <= {SUM_W{1'b0}};
            snap_cnt_r <= {CNT_W{1'b0}};
            rem_r      <= {(SUM_W + 1){1'b0}};
            q_r        <= {XW{1'b0}};
            bit_idx_r  <= {IW{1'b0}};
        end else begin
            if (fe_accept_s) begin
                snap_sum_r <= acc_sum_next_s;
                snap_cnt_r <= acc_cnt_next_s;
            end
            case (state_r)
                ST_CHECK: begin
                    rem_r     <= {1'b0, snap_sum_r};
                    q_r       <= {XW{1'b0}};
                    bit_idx_r <= LAST_BIT;
                end
                ST_DIV: begin
                    rem_r     <= div_rem_s;
                    q_r       <= q_step_s;
                    bit_idx_r <= (bit_idx_r == {IW{1'b0}}) ? bit_idx_r : (bit_idx_r - {{(IW-1){1'b0}}, 1'b1});
                end
                default: begin
                    rem_r     <= rem_r;
                    q_r       <= q_r;
                    bit_idx_r <= bit_idx_r;
                end
            endcase
        end
    end

    // Output registers. x and x_valid load on the last DIV step, so both are visible during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= X_INIT;
            x_valid_r   <= 1'b0;
            no_target_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef FACE_X_SMOOTH_EN
            load_direct_r <= 1'b1;
`endif
        end else begin
            x_valid_r <= div_last_s;
            busy_r    <= (state_next_s != ST_IDLE);
            overrun_r <= fe_drop_s;
            if (fe_accept_s) begin
                no_target_r <= (acc_cnt_next_s < MIN_HITS);
            end
            if (div_last_s) begin
                x_r <= x_new_s;
            end
`ifdef FACE_X_SMOOTH_EN
            if (fe_accept_s && (acc_cnt_next_s < MIN_HITS)) begin
                load_direct_r <= 1'b1;
            end else if (div_last_s) begin
                load_direct_r <= 1'b0;
            end
`endif
        end
    end

    assign x         = x_r;
    assign x_valid   = x_valid_r;
    assign no_target = no_target_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_face_x_tracker.sv
// ----------------------------------------------------------------------------
// Testbench for face_x_tracker. Frames are built from directed and $urandom
// pixel streams. A reference model computes the expected centroid from the
// frame's hit list as floor(sum/count), then applies the hit threshold, the
// clamp and the optional smoothing.
// ----------------------------------------------------------------------------
module tb_face_x_tracker;

    logic       clk = 1'b0;
    logic       rst, frame_start, frame_end, pix_valid, pix_hit;
    logic [9:0] pix_x;
    logic [9:0] x;
    logic       x_valid, no_target, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_end   = 0;
    int m_sum, m_cnt, mx, ne;
    bit m_first;

    always #5 clk = ~clk;

    face_x_tracker dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_x(pix_x),
        .x(x), .x_valid(x_valid), .no_target(no_target), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply one cycle of inputs, clock it in, and land #1 after the edge.
    task automatic drive(input logic fs, input logic fe, input logic v, input logic h, input logic [9:0] px);
        frame_start = fs; frame_end = fe; pix_valid = v; pix_hit = h; pix_x = px;
        @(posedge clk); #1;
        cyc++;
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; pix_x = 10'd0;
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    endtask

    // mode 0: all at xa; 1: first half xa, second half xb; 2: random in [xa,xb]; 3: first pixel xa, rest xb
    task automatic gen_frame(input int nh, input int mode, input int xa, input int xb);
        int px;
        m_sum = 0; m_cnt = 0;
        for (int k = 0; k < nh; k++) begin
            case (mode)
                0:       px = xa;
                1:       px = (k < nh / 2) ? xa : xb;
                2:       px = int'($urandom_range(xb, xa));
                default: px = (k == 0) ? xa : xb;
            endcase
            if (k > 0) begin
                case ($urandom_range(3, 0))
                    0:       drive(1'b0, 1'b0, 1'b1, 1'b0, 10'($urandom_range(639, 0)));
                    1:       drive(1'b0, 1'b0, 1'b0, 1'b1, 10'($urandom_range(639, 0)));
                    default: ;
                endcase
            end
            drive(k == 0, k == nh - 1, 1'b1, 1'b1, 10'(px));
            m_sum += px;
            m_cnt++;
        end
        n_end = cyc - 1;
    endtask

    // Check the result window of the frame ending at n_end against the model.
    task automatic expect_result(input string tag);
        int q;
        if (m_cnt < 256) begin
            check({tag, "_no_target"}, 32'(no_target), 32'd1);
            check({tag, "_busy_check"}, 32'(busy), 32'd1);
            tick();
            check({tag, "_busy_idle"}, 32'(busy), 32'd0);
            while (cyc < n_end + 14) begin
                check({tag, "_no_strobe"}, 32'(x_valid), 32'd0);
                tick();
            end
            check({tag, "_x_hold"}, 32'(x), 32'(mx));
            m_first = 1'b1;
        end else begin
            if (cyc == n_end + 1) begin
                check({tag, "_no_target"}, 32'(no_target), 32'd0);
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            while (cyc < n_end + 12) begin
                check({tag, "_early_strobe"}, 32'(x_valid), 32'd0);
                check({tag, "_overrun_quiet"}, 32'(overrun), 32'd0);
                tick();
            end
            q = m_sum / m_cnt;
            if (q > 639) q = 639;
`ifdef FACE_X_SMOOTH_EN
            mx = m_first ? q : (3 * mx + q) / 4;
`else
            mx = q;
`endif
            m_first = 1'b0;
            check({tag, "_x_valid"}, 32'(x_valid), 32'd1);
            check({tag, "_x"}, 32'(x), 32'(mx));
            check({tag, "_busy_done"}, 32'(busy), 32'd1);
            tick();
            check({tag, "_strobe_end"}, 32'(x_valid), 32'd0);
            check({tag, "_busy_end"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; pix_x = 10'd0;
        mx = 320; m_first = 1'b1;
        @(posedge clk); #1; cyc++;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        check("rst_x", 32'(x), 32'd320);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_no_target", 32'(no_target), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();

        gen_frame(300, 0, 100, 0);     expect_result("const100");
        tick();
        gen_frame(300, 1, 40, 441);    expect_result("split240");
        tick();
        gen_frame(255, 0, 600, 0);     expect_result("hits255");
        tick();
        gen_frame(256, 0, 500, 0);     expect_result("hits256");
        tick();

        // Overrun: a second frame, beginning with a hit on its frame_start cycle, ends at N+5.
        gen_frame(300, 0, 100, 0);
        ne = n_end;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'd600);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd600);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd600);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd600);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd600);
        check("overrun_cycle", 32'(cyc - ne), 32'd6);
        check("overrun_pulse", 32'(overrun), 32'd1);
        tick();
        check("overrun_once", 32'(overrun), 32'd0);
        expect_result("overrun_first");
        while (cyc < ne + 22) begin
            check("dropped_no_strobe", 32'(x_valid), 32'd0);
            tick();
        end

        // Stale accumulator contents must be cleared, but the frame_start hit must still count.
        gen_frame(300, 3, 639, 0);     expect_result("start_hit");
        tick();
        gen_frame(300, 0, 639, 0);     expect_result("edge639");
        tick();
        gen_frame(300, 0, 0, 0);       expect_result("edge0");
        tick();

        for (int r = 0; r < 5; r++) begin
            int lo;
            lo = int'($urandom_range(600, 0));
            gen_frame(int'($urandom_range(400, 240)), 2, lo, int'($urandom_range(639, lo)));
            expect_result("random");
            tick();
        end

        // Reset in the middle of DIV aborts the division.
        gen_frame(300, 2, 50, 600);
        while (cyc < n_end + 5) tick();
        rst = 1'b1;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        check("div_rst_x", 32'(x), 32'd320);
        check("div_rst_busy", 32'(busy), 32'd0);
        mx = 320; m_first = 1'b1;
        while (cyc < n_end + 15) begin
            check("div_rst_no_strobe", 32'(x_valid), 32'd0);
            tick();
        end
        check("div_rst_x_hold", 32'(x), 32'd320);

        gen_frame(300, 0, 100, 0);     expect_result("seq100");
        tick();
        gen_frame(300, 0, 200, 0);     expect_result("seq200");
`ifdef FACE_X_SMOOTH_EN
        check("smooth_125", 32'(x), 32'd125);
`else
        check("direct_200", 32'(x), 32'd200);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
